// File: rtl/wbus_arbiter.sv
// Four-requester round-robin bus arbiter with a per-owner hold limit and lock.
// Grants are registered; the data path from the selected source to WBUS is combinational.
module wbus_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic        CLK,
   input  logic        CLR,
   input  logic [3:0]  req,
   input  logic [3:0]  lock,
   input  logic [15:0] d0,
   input  logic [15:0] d1,
   input  logic [15:0] d2,
   input  logic [15:0] d3,
   output logic [3:0]  gnt,
   output logic [15:0] WBUS,
   output logic        bus_busy,
   output logic [1:0]  owner,
   output logic        preempt
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    gnt_reg, gnt_next;
   logic [1:0]    ptr_reg, ptr_next;
   logic [1:0]    owner_reg, owner_next;
   logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
   logic          preempt_reg, preempt_next;

   logic [3:0]    owner_mask;
   logic [3:0]    others;
   logic [2:0]    pick_all;
   logic [2:0]    pick_oth;
   logic          do_grant;
   logic [1:0]    grant_idx;

   // Returns {found, index} of the first set candidate searching from start upward, mod 4.
   function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] start);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = start + 2'(i);
         if (cand[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   assign owner_mask = 4'b0001 << owner_reg;
   assign others     = req & ~owner_mask;
   assign pick_all   = rr_pick(req, ptr_reg);
   assign pick_oth   = rr_pick(others, ptr_reg);

   always_comb begin
      state_next    = state_reg;
      gnt_next      = gnt_reg;
      ptr_next      = ptr_reg;
      owner_next    = owner_reg;
      hold_cnt_next = hold_cnt_reg;
      preempt_next  = 1'b0;
      do_grant      = 1'b0;
      grant_idx     = 2'd0;

      case (state_reg)
         IDLE: begin
            if (pick_all[2]) begin
               do_grant  = 1'b1;
               grant_idx = pick_all[1:0];
            end
         end
         OWNED: begin
            if (!req[owner_reg]) begin
               if (pick_oth[2]) begin
                  do_grant  = 1'b1;
                  grant_idx = pick_oth[1:0];
               end else begin
                  state_next    = IDLE;
                  gnt_next      = 4'b0000;
                  hold_cnt_next = '0;
               end
            end else if (hold_cnt_reg == HOLD_MAX && !lock[owner_reg] && pick_oth[2]) begin
               // The current owner is excluded from the search, so it cannot win itself back.
               do_grant     = 1'b1;
               grant_idx    = pick_oth[1:0];
               preempt_next = 1'b1;
            end else if (hold_cnt_reg != HOLD_MAX) begin
               hold_cnt_next = hold_cnt_reg + HW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
         end
      endcase

      if (do_grant) begin
         state_next    = OWNED;
         gnt_next      = 4'b0001 << grant_idx;
         owner_next    = grant_idx;
         ptr_next      = grant_idx + 2'd1;
         hold_cnt_next = HW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_reg    <= IDLE;
         gnt_reg      <= 4'b0000;
         ptr_reg      <= 2'd0;
         owner_reg    <= 2'd0;
         hold_cnt_reg <= '0;
         preempt_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         gnt_reg      <= gnt_next;
         ptr_reg      <= ptr_next;
         owner_reg    <= owner_next;
         hold_cnt_reg <= hold_cnt_next;
         preempt_reg  <= preempt_next;
      end
   end

   always_comb begin
      WBUS = 16'h0000;
      if (state_reg == OWNED) begin
         case (owner_reg)
            2'd0:    WBUS = d0;
            2'd1:    WBUS = d1;
            2'd2:    WBUS = d2;
            default: WBUS = d3;
         endcase
      end
   end

   assign gnt      = gnt_reg;
   assign bus_busy = |gnt_reg;
   assign owner    = owner_reg;
   assign preempt  = preempt_reg;

endmodule

// File: tb/tb_wbus_arbiter.sv
// Scoreboard bench for wbus_arbiter: a behavioural model predicts each cycle's outputs,
// a separate monitor compares them against the DUT after every rising edge.
module tb_wbus_arbiter;

   localparam int MAX_HOLD = 4;

   logic        CLK = 1'b0;
   logic        CLR;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [15:0] d0, d1, d2, d3;
   logic [3:0]  gnt;
   logic [15:0] WBUS;
   logic        bus_busy;
   logic [1:0]  owner;
   logic        preempt;

   wbus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .CLK(CLK), .CLR(CLR), .req(req), .lock(lock),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .gnt(gnt), .WBUS(WBUS), .bus_busy(bus_busy), .owner(owner), .preempt(preempt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  gnt;
      logic [1:0]  owner;
      logic        preempt;
      logic        busy;
      logic [15:0] wbus;
   } exp_t;

   exp_t exp_q[$];
   int   tests  = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Reference model: who holds the bus, for how long, and where the next search begins.
   bit          m_owned;
   int          m_owner;
   int          m_ptr;
   int          m_held;
   bit          m_pre;
   logic [15:0] dv[4];

   function automatic int rr_first(input logic [3:0] cand, input int start);
      for (int off = 0; off < 4; off++) begin
         if (cand[(start + off) % 4]) return (start + off) % 4;
      end
      return -1;
   endfunction

   function automatic void m_grant(input int k);
      m_owned = 1'b1;
      m_owner = k;
      m_ptr   = (k + 1) % 4;
      m_held  = 1;
   endfunction

   task automatic step(input logic clr, input logic [3:0] r, input logic [3:0] l);
      logic [3:0] oth;
      exp_t       e;
      CLR  = clr;
      req  = r;
      lock = l;
      d0   = 16'($urandom);
      d1   = 16'($urandom_range(0, 255));
      d2   = 16'($urandom_range(0, 255));
      d3   = 16'($urandom);
      dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;

      m_pre = 1'b0;
      if (clr) begin
         m_owned = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0;
      end else if (!m_owned) begin
         if (r != 4'b0000) m_grant(rr_first(r, m_ptr));
      end else begin
         oth = r;
         oth[m_owner] = 1'b0;
         if (!r[m_owner]) begin
            if (oth != 4'b0000) m_grant(rr_first(oth, m_ptr));
            else m_owned = 1'b0;
         end else if (m_held >= MAX_HOLD && !l[m_owner] && oth != 4'b0000) begin
            m_grant(rr_first(oth, m_ptr));
            m_pre = 1'b1;
         end else begin
            m_held++;
         end
      end

      e.req     = r;
      e.gnt     = m_owned ? 4'(1 << m_owner) : 4'b0000;
      e.owner   = 2'(m_owner);
      e.preempt = m_pre;
      e.busy    = m_owned;
      e.wbus    = m_owned ? dv[m_owner] : 16'h0000;
      exp_q.push_back(e);
      @(negedge CLK);
   endtask

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      tests++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL cyc %0d %s got %h expected %h", cyc, name, got, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("[TB] cyc %0d req=%b gnt=%b owner=%0d preempt=%b busy=%b WBUS=%h",
                     cyc, e.req, gnt, owner, preempt, bus_busy, WBUS);
            chk("gnt",      16'(gnt),      16'(e.gnt));
            chk("owner",    16'(owner),    16'(e.owner));
            chk("preempt",  16'(preempt),  16'(e.preempt));
            chk("bus_busy", 16'(bus_busy), 16'(e.busy));
            chk("WBUS",     WBUS,          e.wbus);
         end
      end
   end

   initial begin : driver
      logic [3:0] r, l;
      logic       c;
      int         wait_cyc;

      // Reset state
      repeat (3) step(1'b1, 4'b0000, 4'b0000);
      // Simple grant and release
      repeat (2) step(1'b0, 4'b0010, 4'b0000);
      repeat (2) step(1'b0, 4'b0000, 4'b0000);
      // Full-load round robin with forced rotations
      repeat (22) step(1'b0, 4'b1111, 4'b0000);
      // Back-to-back handover 2 -> 0
      step(1'b1, 4'b0000, 4'b0000);
      repeat (2) step(1'b0, 4'b0100, 4'b0000);
      repeat (2) step(1'b0, 4'b0001, 4'b0000);
      // Locked owner 3, then unlock
      step(1'b1, 4'b0000, 4'b0000);
      step(1'b0, 4'b1000, 4'b1000);
      repeat (10) step(1'b0, 4'b1001, 4'b1000);
      repeat (3) step(1'b0, 4'b1001, 4'b0000);
      // Sole requester
      repeat (20) step(1'b0, 4'b0100, 4'b0000);
      // Reset mid-ownership
      step(1'b1, 4'b0000, 4'b0000);
      repeat (2) step(1'b0, 4'b0010, 4'b0000);
      step(1'b0, 4'b0011, 4'b0000);
      step(1'b1, 4'b0011, 4'b0000);
      repeat (2) step(1'b0, 4'b0011, 4'b0000);

      // Randomized traffic with sticky requests so hold limits are reached
      r = 4'b0000;
      l = 4'b0000;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom);
         if ($urandom_range(0, 7) == 0) l = 4'($urandom);
         c = ($urandom_range(0, 63) == 0);
         step(c, r, l);
      end

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 5) begin
         @(negedge CLK);
         wait_cyc++;
      end
      tests++;
      if (exp_q.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain pending %0d expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
